param_sum_accumulator: RTL and testbench
========================================

Name: param_sum_accumulator

Overview:
- Consumer-side counterpart to the parameterized constant-driver submodules in the simple_tests family.
- Accepts a valid/ready stream of WIDTH-bit operands and adds parameter P to each accepted operand.
- Accumulates BEATS accepted operands into one sum, then presents the sum on a valid/ready output with a sticky overflow flag.
- Instantiated under a top as a parameterized child, so elaboration produces a derived (paramod) module per P value.

Parameters:
- P, 1: signed 32-bit constant added to every accepted operand; sign-extended/truncated to WIDTH.
- WIDTH, 32: operand and sum width, in bits; legal range 1..32.
- BEATS, 4: operands per result; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  operand.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  accumulated sum, modulo 2^WIDTH.
- out_overflow  output  1  carry-out of WIDTH occurred during this result.
- beat_count  output  8  operands accepted toward the current result.

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of clock; state held until the first rising clk after rst_n deasserts.
  - State to IDLE.
  - in_ready=0.
  - out_valid=0.
  - out_sum=0.
  - out_overflow=0.
  - beat_count=0.
  - Internal accumulator=0.
- FSM states:
  - IDLE: in_ready=1; accumulator=0, overflow=0.
  - ACCUM: in_ready=1.
  - HOLD: in_ready=0, out_valid=1.
- Input handshake: an operand is accepted when in_valid && in_ready at a rising clk edge; in_data is ignored otherwise.
- On each accepted operand:
  - acc_next = acc + in_data + P, computed at WIDTH+2 bits.
  - Stored acc is the low WIDTH bits.
  - Overflow flag ORs in any bit above WIDTH; the flag is sticky per result.
  - beat_count increments.
- Transitions:
  - IDLE -> ACCUM on the first accept when BEATS>1.
  - ACCUM stays in ACCUM while beat_count+1 < BEATS.
  - The BEATS-th accept (from IDLE or ACCUM) -> HOLD.
  - In HOLD: out_sum and out_overflow take the final values, beat_count=BEATS.
- Latency: out_valid rises in the cycle immediately after the edge that accepts the last operand.
- Output hold: in HOLD, out_sum, out_overflow and out_valid remain stable until out_valid && out_ready at a rising edge.
- Output handshake: on that edge the block moves HOLD -> IDLE.
  - out_valid=0, beat_count=0.
  - out_sum and out_overflow keep their last values; they are don't-care while out_valid=0.
  - in_ready=1 on the next cycle.
  - Minimum spacing between results is BEATS+1 cycles.
- Simultaneous events:
  - in_valid is ignored in HOLD, since in_ready=0.
  - out_ready has no effect outside HOLD.
- Reset mid-operation: partial accumulation is discarded; the first result after reset contains only post-reset operands.
- Gaps: deasserting in_valid between operands stalls accumulation indefinitely with no timeout.
- Negative P: two's-complement addition; wrap below zero sets out_overflow only on carry-out. Underflow is not flagged separately.

Test Plan:
- P=1, WIDTH=32, BEATS=4; in_valid held high with in_data=2 for four beats -> out_valid one cycle after the 4th accept, out_sum=12, out_overflow=0, beat_count=4.
- Four beats of in_data=0xFFFFFFFF with P=1 -> each beat adds 0 with carry; out_sum=0, out_overflow=1.
- Backpressure: after a result, hold out_ready=0 for 5 cycles with in_valid=1 -> out_sum and out_valid stable, in_ready=0, no operand accepted. Raise out_ready -> in_ready=1 next cycle.
- Reset mid-stream: accept 2 beats of 5, pulse rst_n low between edges -> outputs zero immediately. Then 4 beats of 1 -> out_sum=8.
- Gapped input: in_valid pattern 1,0,0,1,0,1,1 with in_data=3 -> exactly four accepts; out_sum=16, beat_count counts only handshakes.
- Back-to-back results with out_ready tied high: two consecutive groups (2,2,2,2) and (0,0,0,0) -> out_sum=12 then out_sum=4, separated by 5 cycles.

Source files
------------

// File: rtl/param_sum_accumulator.sv
// param_sum_accumulator
//   Accepts a valid/ready stream of WIDTH-bit operands. It adds the constant P
//   to each accepted operand and accumulates BEATS of them into one sum. The
//   sum is then presented on a valid/ready output together with a sticky
//   carry-out flag.
//
// Parameters
//   P      signed constant added to every accepted operand (truncated to WIDTH)
//   WIDTH  operand / sum width, 1..32
//   BEATS  operands per result, 1..255
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operand valid
//   in_ready     block can accept an operand (registered)
//   in_data      operand
//   out_valid    result valid (registered)
//   out_ready    downstream accepts the result
//   out_sum      accumulated sum modulo 2^WIDTH
//   out_overflow a carry out of WIDTH bits occurred while building this result
//   beat_count   operands accepted toward the current result
module param_sum_accumulator #(
  parameter int          P     = 1,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BEATS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_overflow,
  output logic [7:0]       beat_count
);

  // P reduced to WIDTH bits and then treated as an unsigned addend. As a
  // result, a negative P wraps through zero as an ordinary carry-out.
  localparam logic [WIDTH-1:0] P_W     = WIDTH'(P);
  localparam logic [7:0]       BEATS_B = 8'(BEATS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_HOLD
  } state_t;

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_ovf_q;
  logic [7:0]       beat_count_q;
  logic [WIDTH-1:0] acc_q;
  logic             ovf_q;

  logic [WIDTH+1:0] sum_ext;
  logic [WIDTH-1:0] acc_d;
  logic             ovf_d;
  logic [7:0]       beat_count_d;
  logic             accept;
  logic             last_beat;

  always_comb begin
    // Three WIDTH-bit addends always fit within WIDTH+2 bits.
    sum_ext      = {2'b00, acc_q} + {2'b00, in_data} + {2'b00, P_W};
    acc_d        = sum_ext[WIDTH-1:0];
    ovf_d        = ovf_q | (|sum_ext[WIDTH+1:WIDTH]);
    beat_count_d = beat_count_q + 8'd1;
    accept       = in_valid & in_ready_q;
    last_beat    = (beat_count_d == BEATS_B);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_ovf_q    <= 1'b0;
      beat_count_q <= '0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          // in_ready leaves reset low; the first edge raises it.
          in_ready_q <= 1'b1;
          if (accept) begin
            beat_count_q <= beat_count_d;
            if (last_beat) begin
              state_q     <= S_HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_sum_q   <= acc_d;
              out_ovf_q   <= ovf_d;
              // Clear the accumulator now so that IDLE always starts from zero.
              acc_q       <= '0;
              ovf_q       <= 1'b0;
            end else begin
              state_q <= S_ACCUM;
              acc_q   <= acc_d;
              ovf_q   <= ovf_d;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_q      <= S_IDLE;
            out_valid_q  <= 1'b0;
            beat_count_q <= '0;
            in_ready_q   <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_sum      = out_sum_q;
  assign out_overflow = out_ovf_q;
  assign beat_count   = beat_count_q;

endmodule

// File: tb/tb_param_sum_accumulator.sv
module tb_param_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        rdy [3];
  logic        vld [3];
  logic        ovf [3];
  logic [7:0]  bc  [3];
  logic [31:0] sum_a;
  logic [7:0]  sum_b;
  logic [4:0]  sum_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: defaults. Instance 1: negative P, narrow width.
  // Instance 2: P truncated by WIDTH, single-beat results.
  param_sum_accumulator #(.P(1), .WIDTH(32), .BEATS(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .out_valid(vld[0]), .out_ready(out_ready),
    .out_sum(sum_a), .out_overflow(ovf[0]), .beat_count(bc[0]));

  param_sum_accumulator #(.P(-3), .WIDTH(8), .BEATS(3)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data[7:0]), .out_valid(vld[1]), .out_ready(out_ready),
    .out_sum(sum_b), .out_overflow(ovf[1]), .beat_count(bc[1]));

  param_sum_accumulator #(.P(100), .WIDTH(5), .BEATS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(in_data[4:0]), .out_valid(vld[2]), .out_ready(out_ready),
    .out_sum(sum_c), .out_overflow(ovf[2]), .beat_count(bc[2]));

  function automatic longint p_of(int i);
    case (i)
      0: return 1;
      1: return -3;
      default: return 100;
    endcase
  endfunction

  function automatic int w_of(int i);
    case (i)
      0: return 32;
      1: return 8;
      default: return 5;
    endcase
  endfunction

  function automatic int b_of(int i);
    case (i)
      0: return 4;
      1: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic logic [63:0] obs_sum(int i);
    case (i)
      0: return {32'b0, sum_a};
      1: return {56'b0, sum_b};
      default: return {59'b0, sum_c};
    endcase
  endfunction

  // Reference model: handshake view plus a list of the accepted operands.
  bit     m_ready [3];
  bit     m_hold  [3];
  int     m_cnt   [3];
  longint m_ops   [3][256];
  longint m_sum   [3];
  bit     m_ovf   [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ready[i] = 1'b0;
      m_hold[i]  = 1'b0;
      m_cnt[i]   = 0;
    end
  endtask

  task automatic compute_result(int i);
    longint m   = 64'sd1 <<< w_of(i);
    longint pw  = ((p_of(i) % m) + m) % m;
    longint acc = 0;
    bit     o   = 1'b0;
    for (int k = 0; k < b_of(i); k++) begin
      longint t = acc + m_ops[i][k] + pw;
      if (t >= m) o = 1'b1;
      acc = t % m;
    end
    m_sum[i] = acc;
    m_ovf[i] = o;
  endtask

  task automatic model_edge(bit v, logic [31:0] d, bit ordy);
    for (int i = 0; i < 3; i++) begin
      longint m = 64'sd1 <<< w_of(i);
      if (m_hold[i]) begin
        if (ordy) begin
          m_hold[i]  = 1'b0;
          m_cnt[i]   = 0;
          m_ready[i] = 1'b1;
        end
      end else begin
        if (m_ready[i] && v) begin
          m_ops[i][m_cnt[i]] = longint'({32'b0, d}) % m;
          m_cnt[i]++;
          if (m_cnt[i] == b_of(i)) begin
            compute_result(i);
            m_hold[i] = 1'b1;
          end
        end
        m_ready[i] = !m_hold[i];
      end
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.in_ready", i), 64'(rdy[i]), 64'(m_ready[i]));
      chk($sformatf("u%0d.out_valid", i), 64'(vld[i]), 64'(m_hold[i]));
      chk($sformatf("u%0d.beat_count", i), 64'(bc[i]), 64'(m_cnt[i]));
      if (m_hold[i]) begin
        chk($sformatf("u%0d.out_sum", i), obs_sum(i), 64'(m_sum[i]));
        chk($sformatf("u%0d.out_overflow", i), 64'(ovf[i]), 64'(m_ovf[i]));
      end
    end
  endtask

  // Drive one cycle's inputs, advance the model across the coming rising
  // edge, then compare on the following falling edge.
  task automatic cycle(bit v, logic [31:0] d, bit ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    model_edge(v, d, ordy);
    @(negedge clk);
    check_all();
  endtask

  task automatic chk_a(string tag, bit v, logic [31:0] s, bit o, logic [7:0] b);
    chk({tag, ".valid"}, 64'(vld[0]), 64'(v));
    chk({tag, ".sum"}, 64'(sum_a), 64'(s));
    chk({tag, ".ovf"}, 64'(ovf[0]), 64'(o));
    chk({tag, ".beats"}, 64'(bc[0]), 64'(b));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_a("reset", 1'b0, 32'd0, 1'b0, 8'd0);
    chk("reset.ready", 64'(rdy[0]), 64'd0);
    check_all();
    rst_n = 1'b1;

    // Basic result: 4 x (2+1)
    cycle(1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'd2, 1'b0);
    chk_a("basic", 1'b1, 32'd12, 1'b0, 8'd4);
    cycle(1'b0, 32'd0, 1'b1);
    chk("basic.release.ready", 64'(rdy[0]), 64'd1);

    // Carry on every beat
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'hFFFF_FFFF, 1'b0);
    chk_a("carry", 1'b1, 32'd0, 1'b1, 8'd4);

    // Backpressure: result held, nothing accepted
    for (int k = 0; k < 5; k++) cycle(1'b1, $urandom, 1'b0);
    chk_a("bp", 1'b1, 32'd0, 1'b1, 8'd4);
    chk("bp.ready", 64'(rdy[0]), 64'd0);
    cycle(1'b0, 32'd0, 1'b1);
    chk("bp.release.ready", 64'(rdy[0]), 64'd1);

    // Asynchronous reset between edges discards partial work
    for (int k = 0; k < 2; k++) cycle(1'b1, 32'd5, 1'b0);
    chk("mid.beats", 64'(bc[0]), 64'd2);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_a("mid.rst", 1'b0, 32'd0, 1'b0, 8'd0);
    chk("mid.rst.ready", 64'(rdy[0]), 64'd0);
    model_reset();
    #1 rst_n = 1'b1;
    cycle(1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'd1, 1'b0);
    chk_a("post_rst", 1'b1, 32'd8, 1'b0, 8'd4);
    cycle(1'b0, 32'd0, 1'b1);

    // Gapped valid: 1,0,0,1,0,1,1
    cycle(1'b1, 32'd3, 1'b0);
    chk("gap.beats1", 64'(bc[0]), 64'd1);
    cycle(1'b0, 32'd3, 1'b0);
    cycle(1'b0, 32'd3, 1'b0);
    chk("gap.beats2", 64'(bc[0]), 64'd1);
    cycle(1'b1, 32'd3, 1'b0);
    cycle(1'b0, 32'd3, 1'b0);
    cycle(1'b1, 32'd3, 1'b0);
    cycle(1'b1, 32'd3, 1'b0);
    chk_a("gap", 1'b1, 32'd16, 1'b0, 8'd4);
    cycle(1'b0, 32'd0, 1'b1);

    // Back-to-back with out_ready tied high: results 5 cycles apart
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'd2, 1'b1);
    chk_a("b2b.first", 1'b1, 32'd12, 1'b0, 8'd4);
    cycle(1'b1, 32'd0, 1'b1);
    chk("b2b.gap.valid", 64'(vld[0]), 64'd0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'd0, 1'b1);
    chk_a("b2b.second", 1'b1, 32'd4, 1'b0, 8'd4);
    cycle(1'b0, 32'd0, 1'b1);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      bit v = ($urandom_range(0, 3) != 0);
      bit r = ($urandom_range(0, 2) == 0);
      logic [31:0] d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                   : 32'($urandom);
      cycle(v, d, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
